// File: rtl/axi_fifo_if.sv
// axi_fifo_if: operand write channel and pairwise-sum read channel of axi_fifo
interface axi_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic              rvalid;
    logic [DATA_W:0]   rdata;
    logic              rready;

    modport master (
        output wdata, wvalid, rvalid,
        input  wready, rdata, rready
    );

    modport slave (
        input  wdata, wvalid, rvalid,
        output wready, rdata, rready
    );
endinterface

// File: rtl/axi_fifo.sv
// axi_fifo: operand FIFO whose read side presents the sum of the two oldest operands.
// Define AXI_FIFO_ALMOST_FULL_EN to hold one slot in reserve (max occupancy DEPTH-1).
module axi_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic      i_clk,
    input  logic      i_reset,
    axi_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rp;
    logic [AW-1:0]     r_wp;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     w_rp1;
    logic              w_wready;
    logic              w_rready;
    logic              w_wr;
    logic              w_rd;

    // Handshake flags and the pair sum, all from registered state only
    always_comb begin
`ifdef AXI_FIFO_ALMOST_FULL_EN
        w_wready = r_cnt < CW'(DEPTH - 1);
`else
        w_wready = r_cnt < CW'(DEPTH);
`endif
        w_rready   = r_cnt >= CW'(2);
        w_wr       = bus.wvalid && w_wready;
        w_rd       = bus.rvalid && w_rready;
        w_rp1      = r_rp + AW'(1);
        bus.wready = w_wready;
        bus.rready = w_rready;
        bus.rdata  = w_rready ? {1'b0, r_mem[r_rp]} + {1'b0, r_mem[w_rp1]} : '0;
    end

    // Pointer and occupancy update; a read retires two operands at once
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rp  <= '0;
            r_wp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_rd) r_rp <= r_rp + AW'(2);
            r_cnt <= r_cnt + CW'(w_wr) - (w_rd ? CW'(2) : CW'(0));
        end
    end

    // Operand storage; contents are meaningless until written, so no reset
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_reset) r_mem[r_wp] <= bus.wdata;
    end
endmodule

// File: tb/tb_axi_fifo.sv
// tb_axi_fifo: randomized and directed checks of axi_fifo against a queue model
module tb_axi_fifo;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
`ifdef AXI_FIFO_ALMOST_FULL_EN
    localparam int CAP = DEPTH - 1;
`else
    localparam int CAP = DEPTH;
`endif

    logic clk = 0;
    logic reset = 1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   q[$];

    axi_fifo_if #(.DATA_W(DATA_W)) bus ();

    axi_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks outputs against the model, applies one clock edge, updates the model
    task automatic step(input bit wv, input int wd, input bit rv, input bit rst);
        bit rd, wr;
        int exp_sum;
        bus.wvalid = wv;
        bus.wdata  = DATA_W'(wd);
        bus.rvalid = rv;
        reset      = rst;
        #1;
        exp_sum = (q.size() >= 2) ? q[0] + q[1] : 0;
        check("wready", int'(bus.wready), int'(q.size() < CAP));
        check("rready", int'(bus.rready), int'(q.size() >= 2));
        check("rdata", int'(bus.rdata), exp_sum);
        rd = rv && q.size() >= 2;
        wr = wv && q.size() < CAP;
        if (rst) q.delete();
        else begin
            if (rd) begin
                void'(q.pop_front());
                void'(q.pop_front());
            end
            if (wr) q.push_back(wd & 'hFF);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wvalid = 0;
        bus.wdata  = '0;
        bus.rvalid = 0;
        @(posedge clk);
        #1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // Basic pair sum and retire
        step(1, 'h12, 0, 0);
        step(1, 'h34, 0, 0);
        check("sum_12_34", int'(bus.rdata), 'h046);
        step(0, 0, 1, 0);
        check("empty_after_read", int'(bus.rready), 0);
        // Carry into bit DATA_W
        step(1, 'hFF, 0, 0);
        step(1, 'h01, 0, 0);
        check("carry", int'(bus.rdata), 'h100);
        step(0, 0, 1, 0);
        step(1, 'hFF, 0, 0);
        step(1, 'hFF, 0, 0);
        check("max_sum", int'(bus.rdata), 'h1FE);
        step(0, 0, 1, 0);
        // Fill to capacity, extra push ignored, then drain in order
        for (int i = 0; i < DEPTH + 1; i++) step(1, 16 * i + 3, 0, 0);
        check("full_wready", int'(bus.wready), 0);
        check("full_count", q.size(), CAP);
        for (int i = 0; i < DEPTH / 2; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Simultaneous push and pop around the pointer wrap
        for (int i = 0; i < 7; i++) step(1, 'hA0 + i, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
        step(1, 'h55, 1, 0);
        step(1, 'h66, 1, 0);
        step(0, 0, 0, 0);
        // Reset wins over concurrent handshakes
        for (int i = 0; i < 5; i++) step(1, 'h20 + i, 0, 0);
        step(1, 'h77, 1, 1);
        check("reset_rready", int'(bus.rready), 0);
        check("reset_wready", int'(bus.wready), 1);
        step(0, 0, 0, 0);
        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
